// File: rtl/rvv_backend_vrf_wr_ctrl.sv
// VRF write-side controller: merges retire writes in program order
// and runs a zero-fill sequencer, with one registered output stage.
`ifndef VLEN
`define VLEN 128
`endif
`ifndef VLENB
`define VLENB (`VLEN/8)
`endif
`ifndef NUM_VRF
`define NUM_VRF 32
`endif

module rvv_backend_vrf_wr_ctrl #(
  parameter int NUM_WP    = 4,
  parameter int VRF_IDX_W = 5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_WP-1:0]                     wr_valid,
  output logic [NUM_WP-1:0]                     wr_ready,
  input  logic [NUM_WP-1:0][VRF_IDX_W-1:0]      wr_vd,
  input  logic [NUM_WP-1:0][`VLENB-1:0]         wr_be,
  input  logic [NUM_WP-1:0][`VLEN-1:0]          wr_data,
  input  logic                                  init_req,
  output logic                                  init_busy,
  output logic [`NUM_VRF-1:0][`VLENB-1:0]       vrf_wen,
  output logic [`NUM_VRF-1:0][`VLEN-1:0]        vrf_wdata,
  output logic [`NUM_VRF-1:0]                   vrf_wr_pend
);

  localparam int NVRF  = `NUM_VRF;
  localparam int NBYTE = `VLENB;

  typedef enum logic {RUN, INIT} state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic [VRF_IDX_W-1:0]           init_cnt;
  logic [VRF_IDX_W-1:0]           init_cnt_nxt;
  logic                           alive;
  logic                           rdy;
  logic [NUM_WP-1:0]              acc;
  logic [NVRF-1:0][NBYTE-1:0]     wen_nxt;
  logic [NVRF-1:0][`VLEN-1:0]     data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      init_cnt <= '0;
      alive    <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      alive    <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    unique case (state)
      RUN: begin
        if (init_req) begin
          state_nxt    = INIT;
          init_cnt_nxt = '0;
        end
      end
      INIT: begin
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == VRF_IDX_W'(NVRF-1))
          state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign init_busy = (state == INIT);
  assign rdy       = alive & (state == RUN) & ~init_req;
  assign wr_ready  = {NUM_WP{rdy}};
  assign acc       = wr_valid & wr_ready;

  // later ports overwrite earlier ones, so the youngest hit wins
  always_comb begin
    wen_nxt  = '0;
    data_nxt = '0;
    for (int r = 0; r < NVRF; r++) begin
      for (int k = 0; k < NUM_WP; k++) begin
        if (acc[k] && wr_vd[k] == VRF_IDX_W'(r)) begin
          for (int b = 0; b < NBYTE; b++) begin
            if (wr_be[k][b]) begin
              wen_nxt[r][b]        = 1'b1;
              data_nxt[r][8*b +: 8] = wr_data[k][8*b +: 8];
            end
          end
        end
      end
    end
    if (state == INIT) begin
      wen_nxt[init_cnt]  = '1;
      data_nxt[init_cnt] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vrf_wen   <= '0;
      vrf_wdata <= '0;
    end else begin
      vrf_wen   <= wen_nxt;
      vrf_wdata <= data_nxt;
    end
  end

  always_comb begin
    vrf_wr_pend = '0;
    for (int r = 0; r < NVRF; r++)
      vrf_wr_pend[r] = |vrf_wen[r];
  end

endmodule

// File: tb/tb_rvv_backend_vrf_wr_ctrl.sv
// Bench for rvv_backend_vrf_wr_ctrl: directed and random writes
// checked against a replay model, plus zero-fill and reset cases.
`ifndef VLEN
`define VLEN 128
`endif
`ifndef VLENB
`define VLENB (`VLEN/8)
`endif
`ifndef NUM_VRF
`define NUM_VRF 32
`endif

module tb_rvv_backend_vrf_wr_ctrl;

  localparam int NWP = 4;
  localparam int NR  = `NUM_VRF;
  localparam int NB  = `VLENB;
  localparam int DW  = `VLEN;

  logic                     clk;
  logic                     rst_n;
  logic [NWP-1:0]           wr_valid;
  logic [NWP-1:0]           wr_ready;
  logic [NWP-1:0][4:0]      wr_vd;
  logic [NWP-1:0][NB-1:0]   wr_be;
  logic [NWP-1:0][DW-1:0]   wr_data;
  logic                     init_req;
  logic                     init_busy;
  logic [NR-1:0][NB-1:0]    vrf_wen;
  logic [NR-1:0][DW-1:0]    vrf_wdata;
  logic [NR-1:0]            vrf_wr_pend;

  logic [NB-1:0]            ew [NR];
  logic [DW-1:0]            ed [NR];
  logic [DW-1:0]            mem [NR];
  int                       n_asrt;
  int                       n_fail;

  rvv_backend_vrf_wr_ctrl #(.NUM_WP(NWP), .VRF_IDX_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_vd       (wr_vd),
    .wr_be       (wr_be),
    .wr_data     (wr_data),
    .init_req    (init_req),
    .init_busy   (init_busy),
    .vrf_wen     (vrf_wen),
    .vrf_wdata   (vrf_wdata),
    .vrf_wr_pend (vrf_wr_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in register file fed by the DUT outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < NR; r++)
        for (int b = 0; b < NB; b++)
          if (vrf_wen[r][b]) mem[r][8*b +: 8] <= vrf_wdata[r][8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int r = 0; r < NR; r++) begin
      ew[r] = '0;
      ed[r] = '0;
    end
  endtask

  task automatic check_out();
    logic [NR-1:0] ep;
    ep = '0;
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("wen[%0d]", r), DW'(vrf_wen[r]), DW'(ew[r]));
      chk($sformatf("wdata[%0d]", r), vrf_wdata[r], ed[r]);
      ep[r] = |ew[r];
    end
    chk("pend", DW'(vrf_wr_pend), DW'(ep));
  endtask

  task automatic idle();
    wr_valid = '0;
    wr_vd    = '0;
    wr_be    = '0;
    wr_data  = '0;
    init_req = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // one cycle: inputs already driven; fill = register zeroed this cycle
  task automatic run_cycle(input bit erdy, input bit ebusy, input int fill);
    #1;
    chk("ready", DW'(wr_ready), erdy ? DW'(4'hF) : DW'(0));
    chk("busy", DW'(init_busy), DW'(ebusy));
    clear_exp();
    if (erdy) begin
      for (int k = 0; k < NWP; k++) begin
        if (wr_valid[k]) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[k][b]) begin
              ew[wr_vd[k]][b]        = 1'b1;
              ed[wr_vd[k]][8*b +: 8] = wr_data[k][8*b +: 8];
            end
          end
        end
      end
    end
    if (fill >= 0) begin
      ew[fill] = '1;
      ed[fill] = '0;
    end
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic rand_ports();
    for (int k = 0; k < NWP; k++) begin
      wr_valid[k] = 1'($urandom_range(0, 1));
      wr_vd[k]    = 5'($urandom_range(0, 7));
      wr_be[k]    = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom());
      wr_data[k]  = rnd_data();
    end
  endtask

  initial begin
    logic [DW-1:0] d4;
    n_asrt = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle();
    clear_exp();

    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", DW'(wr_ready), DW'(0));
    chk("rst_busy", DW'(init_busy), DW'(0));
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single write
    wr_valid[0] = 1'b1;
    wr_vd[0]    = 5'd3;
    wr_be[0]    = '1;
    wr_data[0]  = {NB{8'hA5}};
    run_cycle(1, 0, -1);
    chk("single_pend", DW'(vrf_wr_pend), DW'(32'h0000_0008));
    chk("single_data", vrf_wdata[3], {NB{8'hA5}});

    // same-vd merge, youngest port wins
    idle();
    wr_valid = 4'b0101;
    wr_vd[0] = 5'd7; wr_be[0] = 16'h000F; wr_data[0] = {NB{8'h11}};
    wr_vd[2] = 5'd7; wr_be[2] = 16'h003C; wr_data[2] = {NB{8'h22}};
    run_cycle(1, 0, -1);
    chk("merge_wen", DW'(vrf_wen[7]), DW'(16'h003F));
    chk("merge_data", vrf_wdata[7], DW'(48'h2222_2222_1111));

    // parallel distinct registers
    idle();
    wr_valid = 4'hF;
    wr_vd[0] = 5'd0; wr_vd[1] = 5'd1; wr_vd[2] = 5'd2; wr_vd[3] = 5'd31;
    for (int k = 0; k < NWP; k++) begin
      wr_be[k]   = '1;
      wr_data[k] = rnd_data();
    end
    run_cycle(1, 0, -1);
    chk("par_pend", DW'(vrf_wr_pend), DW'(32'h8000_0007));

    // back-to-back same vd with zero-be request mixed in
    idle();
    wr_valid = 4'b0011;
    wr_vd[0] = 5'd9; wr_be[0] = 16'hFF00; wr_data[0] = rnd_data();
    wr_vd[1] = 5'd9; wr_be[1] = 16'h0000; wr_data[1] = rnd_data();
    run_cycle(1, 0, -1);
    wr_be[0] = 16'h00FF; wr_data[0] = rnd_data();
    run_cycle(1, 0, -1);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      idle();
      rand_ports();
      run_cycle(1, 0, -1);
    end

    // preload v5, then write in T-1, then init_req with requests in T
    idle();
    wr_valid[0] = 1'b1; wr_vd[0] = 5'd5;
    wr_be[0] = '1; wr_data[0] = '1;
    run_cycle(1, 0, -1);
    idle();
    wr_valid[1] = 1'b1; wr_vd[1] = 5'd9;
    wr_be[1] = 16'h00FF; wr_data[1] = rnd_data();
    run_cycle(1, 0, -1);
    chk("preload_v5", mem[5], '1);
    idle();
    rand_ports();
    wr_valid = 4'hF;
    init_req = 1'b1;
    run_cycle(0, 0, -1);
    for (int c = 1; c <= NR; c++) begin
      idle();
      rand_ports();
      init_req = (c == 5);
      run_cycle(0, 1, c - 1);
    end
    idle();
    d4 = rnd_data();
    wr_valid[0] = 1'b1; wr_vd[0] = 5'd4;
    wr_be[0] = '1; wr_data[0] = d4;
    run_cycle(1, 0, -1);
    idle();
    run_cycle(1, 0, -1);
    chk("fill_v5", mem[5], '0);
    chk("post_fill_v4", mem[4], d4);

    // reset while init_cnt == 10
    idle();
    init_req = 1'b1;
    run_cycle(0, 0, -1);
    init_req = 1'b0;
    for (int i = 0; i < 10; i++) run_cycle(0, 1, i);
    chk("pre_rst_busy", DW'(init_busy), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    clear_exp();
    chk("mid_rst_busy", DW'(init_busy), DW'(0));
    chk("mid_rst_ready", DW'(wr_ready), DW'(0));
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out();
    wr_valid[3] = 1'b1; wr_vd[3] = 5'd12;
    wr_be[3] = 16'hF0F0; wr_data[3] = rnd_data();
    run_cycle(1, 0, -1);
    idle();
    run_cycle(1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
